// File: rtl/cla_serial_add16.sv
// Digit-serial adder: two WIDTH-bit operands are added DIGIT bits per clock
// through a carry-look-ahead slice, least-significant digit first, with a
// registered carry between digits. Result is returned on a valid/ready port.
// WIDTH must be an integer multiple of DIGIT.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for operands, in_ready=1
// S_RUN  | adding one digit per clock, NDIG clocks in total
// S_DONE | result presented with out_valid=1, held until out_ready

// One CLA slice. Each carry is a flat sum of products of g/p terms and the
// slice carry-in, so no carry depends on a lower computed carry.
module cla_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic [DIGIT:0]   carry
);

  logic [DIGIT-1:0] gen;
  logic [DIGIT-1:0] prop;
  logic             prod;
  logic             term;

  assign gen  = a & b;
  assign prop = a ^ b;

  // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built term by term
  always_comb begin
    carry    = '0;
    prod     = 1'b0;
    term     = 1'b0;
    carry[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      term = 1'b0;
      for (int j = 0; j <= i; j++) begin
        prod = gen[j];
        for (int k = j + 1; k <= i; k++) begin
          prod = prod & prop[k];
        end
        term = term | prod;
      end
      prod = cin;
      for (int k = 0; k <= i; k++) begin
        prod = prod & prop[k];
      end
      carry[i+1] = term | prod;
    end
  end

  assign sum = prop ^ carry[DIGIT-1:0];

endmodule

module cla_serial_add16 #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic              carry_r;
  logic [CW-1:0]     cnt;

  logic [DIGIT-1:0]  slice_sum;
  logic [DIGIT:0]    slice_c;
  logic              last_digit;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  cla_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry_r),
    .sum   (slice_sum),
    .carry (slice_c)
  );

  assign last_digit = (cnt == CW'(NDIG - 1));
  // new digit enters at the top; the whole word moves down by one digit
  assign sum_cat    = {slice_sum, sum};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)   state_nxt = S_RUN;
      S_RUN:  if (last_digit) state_nxt = S_DONE;
      S_DONE: if (out_ready)  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // operand capture, per-digit shift/add and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= cin;
            cnt     <= '0;
            sum     <= '0;
          end
        end
        S_RUN: begin
          sum     <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          a_sh    <= a_sh >> DIGIT;
          b_sh    <= b_sh >> DIGIT;
          carry_r <= slice_c[DIGIT];
          cnt     <= cnt + CW'(1);
          if (last_digit) begin
            cout <= slice_c[DIGIT];
            // carry into the MSB XOR carry out of the MSB
            ovf  <= slice_c[DIGIT-1] ^ slice_c[DIGIT];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // handshake outputs decode straight from the state register
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_cla_serial_add16.sv
// Directed bench for cla_serial_add16 with an expected-result queue.
module tb_cla_serial_add16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  res_t last_exp;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  cla_serial_add16 #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    res_t     r;
    logic [W:0] t;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present operands in IDLE for one edge; returns #1 after the accept edge
  task automatic drive_accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                              input bit push);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    if (push) exp_q.push_back(model(x, y, ci));
    step();
    in_valid = 1'b0;
  endtask

  // follow RUN to DONE, checking handshake, latency and the result
  task automatic wait_result(input bit scramble, input bit early_ready);
    int n = 0;
    out_ready = early_ready;
    while (out_valid !== 1'b1 && n < 20) begin
      chk("run_in_ready", 32'(in_ready), 32'd0);
      chk("run_busy", 32'(busy), 32'd1);
      if (scramble) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
      end
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    if (exp_q.size() > 0) last_exp = exp_q.pop_front();
    else last_exp = '0;
    chk("sum", 32'(sum), 32'(last_exp.sum));
    chk("cout", 32'(cout), 32'(last_exp.cout));
    chk("ovf", 32'(ovf), 32'(last_exp.ovf));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("consume_out_valid", 32'(out_valid), 32'd0);
    chk("consume_in_ready", 32'(in_ready), 32'd1);
    chk("consume_busy", 32'(busy), 32'd0);
  endtask

  task automatic full_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input bit scramble, input bit early_ready);
    drive_accept(x, y, ci, 1'b1);
    wait_result(scramble, early_ready);
    consume();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    step();

    full_add(16'h0005, 16'h0006, 1'b1, 1'b0, 1'b0);
    full_add(16'h0005, 16'h0006, 1'b0, 1'b0, 1'b0);
    full_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    full_add(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    full_add(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    full_add(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    full_add(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // out_ready already high during RUN has no effect before DONE
    full_add(16'h1234, 16'h0FF0, 1'b1, 1'b0, 1'b1);

    // operands changing every RUN cycle are ignored
    full_add(16'h3C3C, 16'h4B4B, 1'b0, 1'b1, 1'b0);
    full_add(16'h7777, 16'h0889, 1'b1, 1'b1, 1'b0);

    // backpressure with new operands pending
    drive_accept(16'h0003, 16'h0004, 1'b0, 1'b1);
    wait_result(1'b0, 1'b0);
    in_valid = 1'b1;
    a        = 16'h1111;
    b        = 16'h0000;
    cin      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'(last_exp.sum));
      chk("bp_cout", 32'(cout), 32'(last_exp.cout));
      chk("bp_ovf", 32'(ovf), 32'(last_exp.ovf));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(model(16'h1111, 16'h0000, 1'b0));
    step();
    in_valid = 1'b0;
    chk("bp_accept_busy", 32'(busy), 32'd1);
    wait_result(1'b0, 1'b0);
    consume();

    // held in_valid: exactly one accept per IDLE visit
    drive_accept(16'h0100, 16'h0200, 1'b0, 1'b1);
    in_valid = 1'b1;
    wait_result(1'b0, 1'b0);
    in_valid = 1'b0;
    consume();

    // asynchronous reset mid-RUN
    drive_accept(16'h1234, 16'h4321, 1'b0, 1'b0);
    step();
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    end
    full_add(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
